// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit:
// op codes, FSM state encoding and the iteration-counter width helper.
package mult_div_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Bits needed to hold values 0..v-1; callers pass WIDTH+1 to count down from WIDTH.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mult_div_unit_restoring_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference only
// when it is non-negative, and shift the resulting quotient bit in.
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtract on a WIDTH+1 bit window so the shifted-out MSB is kept.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit
// with a start/busy/done handshake feeding the HI/LO registers.
// Optional feature macro: MULTDIV_DIVZERO_EXC_EN -- when defined, a DIV with
// a zero divisor skips iteration, leaves hi/lo unchanged and pulses div_zero.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = clog2(WIDTH + 1);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic                 op_q;
  logic                 sa_q;      // dividend sign: remainder takes it
  logic                 neg_q;     // quotient needs negation
  // Multiplicand and accumulator carry one guard bit so that subtracting
  // the most negative multiplicand cannot overflow before the shift.
  logic [WIDTH:0]       mcand_q;
  logic [2*WIDTH+1:0]   p_q;
  logic [2*WIDTH+1:0]   p_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvsr_q;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 busy_q, done_q, dz_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
  logic                 dzp_q;     // current op is a divide by zero
`endif

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       acc, acc_n;
  logic [WIDTH-1:0]     div_lo, div_hi;

  assign a_abs = a[WIDTH-1] ? -a : a;
  assign b_abs = b[WIDTH-1] ? -b : b;

  // Booth step: add/subtract multiplicand from the top half per the
  // recoded bit pair, then arithmetic shift the whole product right by one.
  always_comb begin
    acc = p_q[2*WIDTH+1:WIDTH+1];
    case (p_q[1:0])
      2'b01:   acc_n = acc + mcand_q;
      2'b10:   acc_n = acc - mcand_q;
      default: acc_n = acc;
    endcase
    p_d = {acc_n[WIDTH], acc_n, p_q[WIDTH:1]};
  end

  restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvsr_q),
    .rem_o (rem_d),
    .quo_o (quo_d)
  );

  // Sign fix-up: truncate toward zero, so remainder follows the dividend.
  assign div_lo = neg_q ? -quo_q : quo_q;
  assign div_hi = sa_q  ? -rem_q : rem_q;

  // Control FSM, iteration datapath and registered handshake/result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      p_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef MULTDIV_DIVZERO_EXC_EN
      dzp_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(WIDTH);
            mcand_q <= {a[WIDTH-1], a};
            p_q     <= {{(WIDTH+1){1'b0}}, b, 1'b0};
            rem_q   <= '0;
            quo_q   <= a_abs;
            dvsr_q  <= b_abs;
            sa_q    <= a[WIDTH-1];
            neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            state_q <= (op == OP_DIV) ? ST_DIV : ST_MULT;
`ifdef MULTDIV_DIVZERO_EXC_EN
            dzp_q   <= (op == OP_DIV) && (b == '0);
            if ((op == OP_DIV) && (b == '0)) state_q <= ST_FIX;
`endif
          end
        end
        ST_MULT: begin
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_FIX;
        end
        ST_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
`ifdef MULTDIV_DIVZERO_EXC_EN
          if (dzp_q) begin
            dz_q <= 1'b1;
          end else
`endif
          if (op_q == OP_MULT) begin
            hi_q <= p_q[2*WIDTH:WIDTH+1];
            lo_q <= p_q[WIDTH:1];
          end else begin
            hi_q <= div_hi;
            lo_q <= div_lo;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULTDIV_DIVZERO_EXC_EN
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
  logic unused_dz;
  assign unused_dz = dz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] MIN = 32'h80000000;

  logic             clock, reset, start, op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, div_zero;
  logic [WIDTH-1:0] hi, lo;

  int passed = 0;
  int total  = 0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one op starting at the current negedge (start edge = cycle 0) and
  // return at the negedge of the done cycle with what was observed there.
  task automatic do_op(input logic o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       output int done_cyc, output logic [WIDTH-1:0] h,
                       output logic [WIDTH-1:0] l, output logic dz, output int busy_err);
    done_cyc = -1; busy_err = 0; h = '0; l = '0; dz = 1'b0;
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clock);
    start = 1'b0; a = ~av; b = $urandom;   // later operand changes must be ignored
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clock);
      if (done === 1'b1) begin
        done_cyc = c; h = hi; l = lo; dz = div_zero;
        if (busy !== 1'b0) busy_err++;
        break;
      end
      if (busy !== 1'b1) busy_err++;
    end
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (hi !== '0) $display("FAIL reset_hi: got %h want 0", hi); else passed++;
    total++; if (lo !== '0) $display("FAIL reset_lo: got %h want 0", lo); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL reset_dz: got %b want 0", div_zero); else passed++;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult();
    logic [WIDTH-1:0] va[6] = '{32'd7, MIN, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [WIDTH-1:0] vb[6] = '{32'hFFFFFFFD, MIN, 32'h10, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [WIDTH-1:0] eh[6] = '{32'hFFFFFFFF, 32'h40000000, 32'h1, 32'h0, 32'h0, 32'h3FFFFFFF};
    logic [WIDTH-1:0] el[6] = '{32'hFFFFFFEB, 32'h0, 32'h23456780, 32'h0, 32'h1, 32'h00000001};
    int dc, be; logic [WIDTH-1:0] h, l; logic dz;
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, va[i], vb[i], dc, h, l, dz, be);
      total++; if (dc !== 34) $display("FAIL mult%0d_latency: got %0d want 34", i, dc); else passed++;
      total++; if (be !== 0) $display("FAIL mult%0d_busy: %0d bad busy cycles want 0", i, be); else passed++;
      total++; if (h !== eh[i]) $display("FAIL mult%0d_hi: got %h want %h", i, h, eh[i]); else passed++;
      total++; if (l !== el[i]) $display("FAIL mult%0d_lo: got %h want %h", i, l, el[i]); else passed++;
      @(negedge clock);
      total++; if (done !== 1'b0) $display("FAIL mult%0d_pulse: done got %b want 0", i, done); else passed++;
      total++; if (lo !== el[i]) $display("FAIL mult%0d_hold: lo got %h want %h", i, lo, el[i]); else passed++;
    end
  endtask

  task automatic test_div();
    logic [WIDTH-1:0] va[5] = '{32'hFFFFFFF9, MIN, 32'd7, 32'd100, 32'hFFFFFF9C};
    logic [WIDTH-1:0] vb[5] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFF9};
    logic [WIDTH-1:0] eh[5] = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'hFFFFFFFE};
    logic [WIDTH-1:0] el[5] = '{32'hFFFFFFFD, MIN, 32'hFFFFFFFD, 32'd14, 32'd14};
    int dc, be; logic [WIDTH-1:0] h, l; logic dz;
    for (int i = 0; i < 5; i++) begin
      do_op(1'b1, va[i], vb[i], dc, h, l, dz, be);
      total++; if (dc !== 34) $display("FAIL div%0d_latency: got %0d want 34", i, dc); else passed++;
      total++; if (be !== 0) $display("FAIL div%0d_busy: %0d bad busy cycles want 0", i, be); else passed++;
      total++; if (h !== eh[i]) $display("FAIL div%0d_hi: got %h want %h", i, h, eh[i]); else passed++;
      total++; if (l !== el[i]) $display("FAIL div%0d_lo: got %h want %h", i, l, el[i]); else passed++;
      total++; if (dz !== 1'b0) $display("FAIL div%0d_dz: got %b want 0", i, dz); else passed++;
      @(negedge clock);
      total++; if (done !== 1'b0) $display("FAIL div%0d_pulse: done got %b want 0", i, done); else passed++;
    end
  endtask

  task automatic test_div_zero();
    int dc, be; logic [WIDTH-1:0] h, l; logic dz;
    do_op(1'b1, 32'd100, 32'd7, dc, h, l, dz, be);   // leaves hi=2, lo=14
    @(negedge clock);
    do_op(1'b1, 32'd5, 32'd0, dc, h, l, dz, be);
`ifdef MULTDIV_DIVZERO_EXC_EN
    total++; if (dc !== 2) $display("FAIL dz_latency: got %0d want 2", dc); else passed++;
    total++; if (dz !== 1'b1) $display("FAIL dz_flag: got %b want 1", dz); else passed++;
    total++; if (h !== 32'd2) $display("FAIL dz_hi_kept: got %h want 2", h); else passed++;
    total++; if (l !== 32'd14) $display("FAIL dz_lo_kept: got %h want e", l); else passed++;
    @(negedge clock);
    total++; if (div_zero !== 1'b0) $display("FAIL dz_pulse: got %b want 0", div_zero); else passed++;
`else
    total++; if (dc !== 34) $display("FAIL dz_latency: got %0d want 34", dc); else passed++;
    total++; if (dz !== 1'b0) $display("FAIL dz_flag: got %b want 0", dz); else passed++;
    total++; if (h !== 32'd5) $display("FAIL dz_hi: got %h want 5", h); else passed++;
    total++; if (l !== 32'hFFFFFFFF) $display("FAIL dz_lo: got %h want ffffffff", l); else passed++;
    @(negedge clock);
    do_op(1'b1, 32'hFFFFFFFB, 32'd0, dc, h, l, dz, be);
    total++; if (h !== 32'hFFFFFFFB) $display("FAIL dzneg_hi: got %h want fffffffb", h); else passed++;
    total++; if (l !== 32'd1) $display("FAIL dzneg_lo: got %h want 1", l); else passed++;
    @(negedge clock);
`endif
  endtask

  task automatic test_reset_midop();
    int dc, be; logic [WIDTH-1:0] h, l; logic dz;
    start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);          // now in cycle 10
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
    total++; if (hi !== '0) $display("FAIL midrst_hi: got %h want 0", hi); else passed++;
    total++; if (lo !== '0) $display("FAIL midrst_lo: got %h want 0", lo); else passed++;
    total++; if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done); else passed++;
    @(negedge clock);
    reset = 1'b1;
    do_op(1'b0, 32'd3, 32'd4, dc, h, l, dz, be);
    total++; if (dc !== 34) $display("FAIL postrst_latency: got %0d want 34", dc); else passed++;
    total++; if (l !== 32'd12) $display("FAIL postrst_lo: got %h want c", l); else passed++;
    @(negedge clock);
  endtask

  task automatic test_start_while_busy();
    int ndone, dcyc; logic [WIDTH-1:0] l;
    ndone = 0; dcyc = -1; l = '0;
    start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
    @(negedge clock);
    for (int c = 1; c <= 80; c++) begin
      start = (c == 5) || (c == 33);       // mid-iteration and FIX-cycle starts
      op = 1'b1; a = 32'd100; b = 32'd7;
      if (done === 1'b1) begin ndone++; dcyc = c; l = lo; end
      @(negedge clock);
    end
    start = 1'b0;
    total++; if (ndone !== 1) $display("FAIL busy_start_ndone: got %0d want 1", ndone); else passed++;
    total++; if (dcyc !== 34) $display("FAIL busy_start_cycle: got %0d want 34", dcyc); else passed++;
    total++; if (l !== 32'd42) $display("FAIL busy_start_lo: got %h want 2a", l); else passed++;
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, be; logic [WIDTH-1:0] h, l; logic dz;
    do_op(1'b0, 32'd3, 32'd5, dc1, h, l, dz, be);
    total++; if (l !== 32'd15) $display("FAIL b2b_first_lo: got %h want f", l); else passed++;
    do_op(1'b1, 32'd20, 32'hFFFFFFFD, dc2, h, l, dz, be);   // started in the done cycle
    total++; if (dc2 !== 34) $display("FAIL b2b_latency: got %0d want 34", dc2); else passed++;
    total++; if (l !== 32'hFFFFFFFA) $display("FAIL b2b_lo: got %h want fffffffa", l); else passed++;
    total++; if (h !== 32'd2) $display("FAIL b2b_hi: got %h want 2", h); else passed++;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_reset_midop();
    test_start_while_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
